// File: rtl/inst_ram_loader.sv
// rtl/inst_ram_loader.sv - writable instruction RAM loaded from a big-endian byte stream with XOR checksum
module inst_ram_loader #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW:0]   load_len,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          busy,
  output logic          load_ok,
  output logic          load_err,
  input  logic [31:0]   addr,
  output logic [31:0]   Inst
);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;

  state_t      state;
  logic [AW:0] len;
  logic [AW:0] ptr;
  logic [1:0]  bcnt;
  logic [23:0] asm_word;
  logic [7:0]  acc;
  logic [31:0] mem [0:(1<<AW)-1];

  logic        bad_len;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        unused_addr;

  // Legal lengths are 1..2^AW; anything with the top bit set plus lower bits is too long.
  assign bad_len    = (load_len == '0) || (load_len[AW] && (load_len[AW-1:0] != '0));
  assign byte_ready = (state != IDLE);
  assign busy       = (state != IDLE);
  assign wr_en      = (state == LOAD) && byte_valid && (bcnt == 2'd3);
  assign wr_data    = {asm_word, byte_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len      <= '0;
      ptr      <= '0;
      bcnt     <= '0;
      asm_word <= '0;
      acc      <= '0;
      load_ok  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (bad_len) begin
              load_ok  <= 1'b0;
              load_err <= 1'b1;
            end else begin
              len      <= load_len;
              ptr      <= '0;
              bcnt     <= '0;
              acc      <= '0;
              load_ok  <= 1'b0;
              load_err <= 1'b0;
              state    <= LOAD;
            end
          end
        end
        LOAD: begin
          if (byte_valid) begin
            acc      <= acc ^ byte_data;
            bcnt     <= bcnt + 2'd1;
            asm_word <= {asm_word[15:0], byte_data};
            if (bcnt == 2'd3) begin
              ptr <= ptr + {{AW{1'b0}}, 1'b1};
              if (ptr == len - {{AW{1'b0}}, 1'b1})
                state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (byte_valid) begin
            state <= IDLE;
            if (byte_data == acc)
              load_ok <= 1'b1;
            else
              load_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // No reset on the array so previously loaded words survive a mid-load reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[ptr[AW-1:0]] <= wr_data;
  end

  assign Inst        = mem[addr[AW+1:2]];
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

endmodule

// File: doc/inst_ram_loader.md
# inst_ram_loader

Writable instruction memory with a byte-stream loader, replacing the fixed instruction ROM so programs can be downloaded at run time. A host, typically a UART receiver, streams big-endian instruction bytes over a valid/ready handshake. The block assembles them into 32-bit words, writes them from word 0 upward, and verifies an XOR checksum. The CPU fetch port reads combinationally, exactly as from the ROM, and `busy` holds the CPU while a load is in progress.

## Interface
- `AW`, 5, word-address width; depth = 2^AW words (32)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE
- `load_len`  in  AW+1  number of words to load, legal range 1..2^AW; sampled with `start`
- `byte_valid`  in  1  host byte available
- `byte_data`  in  8  host byte
- `byte_ready`  out  1  loader accepts a byte this cycle
- `busy`  out  1  load in progress; drives CPU hold/stall
- `load_ok`  out  1  sticky: last load completed and checksum matched
- `load_err`  out  1  sticky: last load had bad `load_len` or checksum mismatch
- `addr`  in  32  fetch byte address (PC)
- `Inst`  out  32  instruction word; `Inst = mem[addr[AW+1:2]]`, combinational

## Operation
- States:
  - IDLE: `busy=0`, `byte_ready=0`.
  - LOAD: receives 4·`load_len` data bytes.
  - CHECK: receives 1 checksum byte.
- Byte transfer occurs on a rising edge where `byte_valid && byte_ready`. `byte_data` is ignored otherwise.
- `byte_ready` and `busy` are decoded from the registered state: both are 1 in LOAD and CHECK.
- IDLE and `start` with `load_len` in 1..2^AW:
  - latch `load_len`; clear word pointer, byte counter and checksum accumulator;
  - clear `load_ok`/`load_err`; go to LOAD.
- IDLE and `start` with `load_len` = 0 or > 2^AW:
  - stay in IDLE; `load_ok`=0, `load_err`=1; memory is untouched.
- LOAD:
  - The first byte of each word goes to bits 31:24, then 23:16, 15:8, 7:0 (big-endian).
  - Each data byte is XORed into the 8-bit accumulator.
  - On acceptance of the 4th byte, the assembled word is written to `mem[word pointer]` and the pointer increments.
  - After word `load_len`-1 is written, go to CHECK.
- CHECK, on acceptance of the checksum byte: go to IDLE.
  - If byte == accumulator: `load_ok`=1.
  - Otherwise: `load_err`=1.
  - Loaded words remain written in either case.
- `start` outside IDLE is ignored.
- Memory has no reset. Words beyond `load_len` keep their previous contents.
- Reset, including mid-load: state→IDLE; `byte_ready`=0, `busy`=0, `load_ok`=0, `load_err`=0; counters and accumulator cleared.
  - A partially assembled word is discarded.
  - Words already written remain in memory.
- Read port is independent of loader state. Reading a word in the same cycle it is written returns the old value.

## Timing
- `start` at edge k: `busy`/`byte_ready` are 1 from after edge k until after the checksum edge.
- Throughput is 1 byte per cycle. A full-rate load of N words takes 4N+1 accepted bytes; `busy` is high for 4N+1 cycles.
- A written word is visible on `Inst` from the cycle after its 4th-byte edge.
- `load_ok`/`load_err` update on the checksum edge, the same edge at which `busy` falls. They hold until the next accepted `start` or reset.
- Bad-`load_len` error: `load_err`=1 after the `start` edge; `busy` never rises.
- Host stalls (`byte_valid`=0) extend LOAD/CHECK indefinitely. There is no timeout.

## Test plan
- Reset with `rst_n`=0, then release → `byte_ready`=0, `busy`=0, `load_ok`=0, `load_err`=0.
- `start`, `load_len`=2; bytes 3c 01 11 00 3c 02 00 11, checksum 03 →
  - `busy` is high for 9 cycles, then `load_ok`=1;
  - `addr`=0 gives `Inst`=0x3c011100; `addr`=4 gives `Inst`=0x3c020011.
- Same stream with checksum 04 → `load_err`=1, `load_ok`=0, both words still written.
- Bubble stall: `byte_valid` deasserted randomly between bytes, `start` pulsed mid-load → identical memory result; extra `start` has no effect.
- Boundary lengths:
  - `load_len`=0 → `load_err`=1 with no ready;
  - `load_len`=33 → `load_err`=1;
  - `load_len`=32 → words 0..31 filled, pointer does not wrap.
- Reset asserted after 6 bytes of a 2-word load → word 0 written, word 1 unchanged, IDLE; a new load then succeeds.
